// File: rtl/encrypter_seq_pkg.sv
// rtl/encrypter_seq_pkg.sv - shared states and job layout constants for the encrypter sequencer
package encrypter_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENC_RST,
    S_ENC_START,
    S_WAIT_DONE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OUT_HOLD
  } seq_state_e;

  // Byte-stream region boundaries: pk poly | seed | coin | message
  localparam int unsigned SEED_LO  = 896;
  localparam int unsigned COIN_LO  = 928;
  localparam int unsigned MSG_LO   = 960;
  localparam int unsigned JOB_END  = 992;

  // input1 word base per region
  localparam int unsigned SEED_WORD_BASE = 8;
  localparam int unsigned COIN_WORD_BASE = 0;
  localparam int unsigned MSG_WORD_BASE  = 16;

  localparam int unsigned CT_LEN = 1088;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - 8->32 big-endian packer, word valid on every 4th byte
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;

  // The 4th byte completes the word combinationally; earliest byte ends in [31:24]
  always_comb begin
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    word_o       = {sh_q, byte_i};
    word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      sh_d  = {sh_q[15:0], byte_i};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Shift register and byte-in-group counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/encrypter_sequencer.sv
// rtl/encrypter_sequencer.sv - loads a job into the encrypter core, runs it and drains the ciphertext
module encrypter_sequencer
  import encrypter_seq_pkg::*;
#(
  parameter int PK_POLY_BYTES = SEED_LO,
  parameter int SEED_BYTES    = COIN_LO - SEED_LO,
  parameter int COIN_BYTES    = MSG_LO - COIN_LO,
  parameter int MSG_BYTES     = JOB_END - MSG_LO,
  parameter int CT_BYTES      = CT_LEN,
  parameter int READ_LAT      = 1,
  parameter int TIMEOUT_CYC   = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        enc_rst,
  output logic        enc_start,
  input  logic        enc_done,
  output logic [31:0] enc_in1_dia,
  output logic        enc_in1_wea,
  output logic [4:0]  enc_in1_addra,
  output logic [7:0]  enc_in2_dia,
  output logic        enc_in2_wea,
  output logic [9:0]  enc_in2_addra,
  output logic [10:0] enc_out_addr,
  input  logic [7:0]  enc_out_do,
  output logic        busy,
  output logic        err
);

  localparam int LO_SEED  = PK_POLY_BYTES;
  localparam int LO_COIN  = LO_SEED + SEED_BYTES;
  localparam int LO_MSG   = LO_COIN + COIN_BYTES;
  localparam int JOB_LAST = LO_MSG + MSG_BYTES - 1;
  localparam int CYC_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  seq_state_e       state_q, state_d;
  logic [9:0]       bc_q, bc_d;
  logic [10:0]      oc_q, oc_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             err_q, err_d;

  logic             enc_rst_q, enc_start_q;
  logic [31:0]      in1_dia_q;
  logic             in1_wea_q;
  logic [4:0]       in1_addra_q;
  logic [7:0]       in2_dia_q;
  logic             in2_wea_q;
  logic [9:0]       in2_addra_q;
  logic [10:0]      out_addr_q;
  logic [7:0]       out_data_q;
  logic             out_valid_q, out_last_q;

  logic             hs, wr_en, out_load, out_clr;
  logic             pk_byte_valid, pk_word_valid;
  logic [31:0]      pk_word;
  logic [9:0]       grp_off;
  logic [4:0]       grp_base, word_addr;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign hs       = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

  // Sequencing FSM: job load, core reset/start, completion wait, ciphertext drain
  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    oc_d     = oc_q;
    cyc_d    = cyc_q;
    lat_d    = lat_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    out_load = 1'b0;
    out_clr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bc_d = '0;
        if (hs) begin
          if (in_last) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            wr_en   = 1'b1;
            bc_d    = 10'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          if (bc_q == 10'(JOB_LAST)) begin
            wr_en   = 1'b1;
            bc_d    = '0;
            state_d = S_ENC_RST;
            if (!in_last) err_d = 1'b1;
          end else if (in_last) begin
            // Truncated job: drop the final byte and everything loaded so far
            err_d   = 1'b1;
            bc_d    = '0;
            state_d = S_IDLE;
          end else begin
            wr_en = 1'b1;
            bc_d  = bc_q + 10'd1;
          end
        end
      end
      S_ENC_RST: begin
        state_d = S_ENC_START;
      end
      S_ENC_START: begin
        // Counter holds cycles elapsed since the start pulse
        cyc_d   = CYC_W'(1);
        oc_d    = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (enc_done) begin
          state_d = S_RD_ADDR;
        end else if (cyc_q == CYC_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_RD_ADDR: begin
        lat_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_W'(READ_LAT - 1)) begin
          out_load = 1'b1;
          state_d  = S_OUT_HOLD;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_OUT_HOLD: begin
        if (out_ready) begin
          out_clr = 1'b1;
          if (oc_q == 11'(CT_BYTES - 1)) begin
            oc_d    = '0;
            state_d = S_IDLE;
          end else begin
            oc_d    = oc_q + 11'd1;
            state_d = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // input1 word address for the group that the current byte completes
  always_comb begin
    grp_off  = '0;
    grp_base = '0;
    if (bc_q < 10'(LO_COIN)) begin
      grp_off  = bc_q - 10'(LO_SEED);
      grp_base = 5'(SEED_WORD_BASE);
    end else if (bc_q < 10'(LO_MSG)) begin
      grp_off  = bc_q - 10'(LO_COIN);
      grp_base = 5'(COIN_WORD_BASE);
    end else begin
      grp_off  = bc_q - 10'(LO_MSG);
      grp_base = 5'(MSG_WORD_BASE);
    end
    word_addr = 5'(grp_off >> 2) + grp_base;
  end

  assign pk_byte_valid = wr_en && (bc_q >= 10'(LO_SEED));

  byte_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (state_q == S_IDLE),
    .byte_valid_i (pk_byte_valid),
    .byte_i       (in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  // FSM state and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bc_q    <= '0;
      oc_q    <= '0;
      cyc_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      oc_q    <= oc_d;
      cyc_q   <= cyc_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  // Registered core-side and output-stream signals
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_rst_q   <= 1'b1;
      enc_start_q <= 1'b0;
      in1_dia_q   <= '0;
      in1_wea_q   <= 1'b0;
      in1_addra_q <= '0;
      in2_dia_q   <= '0;
      in2_wea_q   <= 1'b0;
      in2_addra_q <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      enc_rst_q   <= (state_d == S_ENC_RST);
      enc_start_q <= (state_d == S_ENC_START);
      in2_wea_q   <= wr_en && (bc_q < 10'(LO_SEED));
      if (wr_en && (bc_q < 10'(LO_SEED))) begin
        in2_addra_q <= bc_q;
        in2_dia_q   <= in_data;
      end
      in1_wea_q <= pk_word_valid;
      if (pk_word_valid) begin
        in1_addra_q <= word_addr;
        in1_dia_q   <= pk_word;
      end
      if (state_d == S_RD_ADDR) begin
        out_addr_q <= oc_d;
      end
      if (out_load) begin
        out_data_q  <= enc_out_do;
        out_valid_q <= 1'b1;
        out_last_q  <= (oc_q == 11'(CT_BYTES - 1));
      end else if (out_clr) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign enc_rst       = enc_rst_q;
  assign enc_start     = enc_start_q;
  assign enc_in1_dia   = in1_dia_q;
  assign enc_in1_wea   = in1_wea_q;
  assign enc_in1_addra = in1_addra_q;
  assign enc_in2_dia   = in2_dia_q;
  assign enc_in2_wea   = in2_wea_q;
  assign enc_in2_addra = in2_addra_q;
  assign enc_out_addr  = out_addr_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;

endmodule

// File: doc/encrypter_sequencer.md
Name: encrypter_sequencer

Overview:
Control front-end for the `encrypter` core. It accepts one encryption job as a byte stream (pk || coin || m, 992 bytes) and scatters it into the core's two input RAM ports. It then resets and starts the core and waits for `done`. Finally it drains the 1088-byte ciphertext from the core's output RAM onto a valid/ready byte stream, replacing the manual load/check sequencing done in simulation.

Parameters:
PK_POLY_BYTES, 896, pk bytes written byte-wise to the input2 port
SEED_BYTES, 32, pk public-seed bytes, packed to input1 words 8..15
COIN_BYTES, 32, coin bytes, packed to input1 words 0..7
MSG_BYTES, 32, message bytes, packed to input1 words 16..23
CT_BYTES, 1088, ciphertext bytes read back
READ_LAT, 1, cycles from enc_out_addr change to valid enc_out_do
TIMEOUT_CYC, 1048576, max cycles in WAIT_DONE before error

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
in_data  in  8  job byte
in_valid  in  1  in_data valid
in_ready  out  1  sequencer accepts a byte this cycle
in_last  in  1  marks the final job byte
out_data  out  8  ciphertext byte
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts the byte
out_last  out  1  high with ciphertext byte 1087
enc_rst  out  1  active-high reset to the core
enc_start  out  1  one-cycle start pulse to the core
enc_done  in  1  core completion level
enc_in1_dia  out  32  packed word to input1 RAM
enc_in1_wea  out  1  input1 write enable
enc_in1_addra  out  5  input1 word address
enc_in2_dia  out  8  byte to input2 RAM
enc_in2_wea  out  1  input2 write enable
enc_in2_addra  out  10  input2 byte address
enc_out_addr  out  11  ciphertext read address
enc_out_do  in  8  ciphertext read data
busy  out  1  high in every state except IDLE
err  out  1  sticky framing/timeout error

Behaviour:
- Reset values: all outputs 0, except `enc_rst` = 1 and `in_ready` = 1; state = IDLE.
- All RAM-side outputs are registered. A write issues the cycle after the in_valid&in_ready handshake; `wea` is high for exactly one cycle.
- Byte counter `bc` runs 0..991.
  - bc 0..895: in2_addra = bc, in2_dia = byte.
  - bc 896..991: big-endian packing; the first byte of each 4-byte group lands in dia[31:24]. The word is written on the 4th byte.
  - Word address: bc 896..927 -> (bc-896)/4+8; bc 928..959 -> (bc-928)/4; bc 960..991 -> (bc-960)/4+16.
- States:
  - IDLE: in_ready = 1. The first handshake clears err, performs the bc=0 write and moves to LOAD.
  - LOAD: in_ready = 1. Each handshake increments bc. The handshake at bc = 991 goes to ENC_RST.
    - in_last at bc < 991: set err, return to IDLE; the partial job is discarded.
    - in_last = 0 at bc = 991: set err, still proceed.
  - ENC_RST: enc_rst = 1 for one cycle, in_ready = 0 from here on.
  - ENC_START: enc_start = 1 for one cycle; the cycle counter is cleared.
  - WAIT_DONE: wait for enc_done = 1, then go to RD_ADDR. When the counter reaches TIMEOUT_CYC, set err and go to IDLE.
  - RD_ADDR: drive enc_out_addr = oc (oc = 0..1087).
  - RD_WAIT: hold for READ_LAT cycles, then register enc_out_do into out_data and assert out_valid.
  - OUT_HOLD: out_data and out_valid stay stable until out_ready. On the handshake: if oc = 1087 go to IDLE with out_last cleared, else oc++ and go to RD_ADDR.
- Throughput: one output byte per READ_LAT+2 cycles when out_ready is held high.
- enc_rst is 0 in all states except ENC_RST and reset.
- Reset mid-operation: immediate return to reset values. The core's RAM contents are undefined; a new job must reload all 992 bytes.
- enc_done already high in the cycle after ENC_START: accepted as completion.

Decomposition:
- Package `encrypter_seq_pkg`: state enum, byte-region boundary constants (896/928/960/992), input1 word base offsets (8/0/16), CT_BYTES.
- One sub-module `byte_word_packer`: 8->32 big-endian packer that emits a word-valid on every 4th byte.

Test Plan:
- Load: random job with in_valid held high -> 896 in2 writes at addr 0..895 and 24 in1 writes. Seed byte 896 = 0xAB lands at in1 addr 8 dia[31:24]; coin byte 0 lands at addr 0; m byte 0 lands at addr 16.
- Full job against a core model with done asserted 500 cycles after start -> enc_rst pulse, then enc_start pulse, then 1088 bytes out. out_last is only on byte 1087 and the bytes match the core RAM.
- Output backpressure: out_ready toggled randomly -> out_data stays stable while out_valid=1 and !out_ready; no bytes are dropped or duplicated.
- Early in_last at byte 100 -> err=1, state IDLE, no enc_start. The next good job clears err and completes.
- Timeout with TIMEOUT_CYC=64 and enc_done never set -> err=1 and return to IDLE exactly 64 cycles after enc_start.
- rst pulled low during OUT_HOLD at byte 500 -> all outputs at reset values immediately, enc_rst=1, busy=0.
